aes_key_schedule_store: RTL and testbench
=========================================

Name: aes_key_schedule_store

Overview:
- Parametrised AES key scheduler for AES-128, AES-192 and AES-256.
- Expands the cipher key one 32-bit word per cycle into an internal round-key store.
- Serves any round key by index, in forward (encrypt) or reversed (decrypt) order.
- Sits between the key register interface and the cipher/inverse-cipher datapath. Because the whole schedule is stored, decryption can start with the last round key without re-running expansion.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128, 192, 256 (anything else is an elaboration error).
Derived (not overridable): NK = KEY_BITS/32 (4/6/8); NR = NK+6 (10/12/14); NW = 4*(NR+1) (44/52/60).

Ports:
clk_sys  in  1  system clock; all logic on its rising edge.
rst_n  in  1  synchronous, active-low reset.
key_start  in  1  one-cycle pulse; loads cipher_key and begins expansion.
cipher_key  in  KEY_BITS  cipher key; MSB word is w[0]. Sampled only on an accepted key_start.
key_busy  out  1  expansion in progress.
key_ready  out  1  store holds a complete, valid schedule.
rk_idx  in  4  requested round number, 0..NR.
rk_dec  in  1  0 = return round rk_idx; 1 = return round NR-rk_idx.
round_key_out  out  128  registered round key; word 4r in [127:96], word 4r+3 in [31:0].

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state IDLE; key_busy=0, key_ready=0, round_key_out=0.
  - Word counter and rcon register are cleared.
  - The word store itself is not reset.
- FSM has three states: IDLE, EXPAND, READY.
- IDLE:
  - key_start=1 loads cipher_key into store words 0..NK-1.
  - Word counter i is set to NK, rcon to 0x01, and the FSM moves to EXPAND.
- EXPAND: one word per cycle, where temp = w[i-1].
  - If i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon then advances by xtime (0x80 -> 0x1B).
  - Else if NK==8 and i mod NK == 4: w[i] = w[i-NK] ^ SubWord(temp).
  - Else: w[i] = w[i-NK] ^ temp.
  - RotWord is a left rotate by one byte. SubWord applies the forward S-box to all 4 bytes.
  - When w[NW-1] is written, the FSM moves to READY.
- Busy/ready timing:
  - key_busy=1 for exactly NW-NK cycles (40/46/52), starting the cycle after key_start.
  - key_ready rises the cycle after the last write: key_start at cycle T gives key_ready=1 at T+1+NW-NK.
- key_start while in EXPAND is ignored; expansion continues unchanged.
- key_start while in READY:
  - Re-keys: key_ready=0 from the next cycle and the FSM enters EXPAND exactly as from IDLE.
  - round_key_out drops to 0 on that same edge.
- Read path, when key_ready=1:
  - Effective round e = rk_dec ? NR-rk_idx : rk_idx.
  - round_key_out <= {w[4e],w[4e+1],w[4e+2],w[4e+3]}, one cycle latency.
  - rk_idx > NR: round_key_out <= 0.
  - When key_ready=0: round_key_out <= 0.
- Arithmetic is GF(2^8) byte-wise XOR only; no carries. The word counter is 6 bits wide.
- Reset asserted mid-expansion aborts the expansion: key_ready stays 0 until a new key_start completes.
- Simultaneous reset and key_start: reset wins.

Optional Feature:
AES_KEY_ZEROIZE_EN
- Defined:
  - Adds input port key_clear (1 bit).
  - key_clear=1 in any state, on the next edge:
    - writes 0 to every store word
    - clears rcon and the word counter
    - sets key_ready=0 and key_busy=0, and the FSM to IDLE
    - sets round_key_out=0
  - The zeroize completes in that single cycle.
  - key_clear has priority over key_start; reset has priority over both.
- Undefined: no key_clear port. Store contents persist until overwritten.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c -> key_busy 40 cycles. Then rk_idx=10, rk_dec=0 gives d014f9a8c9ee2589e13f0cc8b6630ca6, and rk_idx=0, rk_dec=1 gives the same value one cycle later.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_busy 46 cycles. rk_idx=12 gives e98ba06f448c773c8ecc720401002202; rk_idx=0 returns the first 128 key bits.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_busy 52 cycles. rk_idx=14 gives fe4890d1e6188d0b046df344706c631e; rk_idx=15 gives 0.
- KEY_BITS=128:
  - key_start pulsed at expansion cycle 20 -> ignored; the original schedule completes on time.
  - key_start in READY with the all-zero key -> key_ready falls next cycle; rk_idx=10 then reads b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset pulsed at expansion cycle 10 -> key_busy=0, key_ready=0, round_key_out=0 next cycle; a reads request returns 0 until a fresh expansion completes.
- With AES_KEY_ZEROIZE_EN: key_clear in READY -> key_ready=0, round_key_out=0 next cycle. After re-expansion of the all-zero key, every intermediate store word matches the reference model (no stale data).

Source files
------------

// File: rtl/aes_key_schedule_store.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_store
//
// Purpose:
//   AES-128/192/256 key scheduler. The cipher key is expanded one 32-bit word
//   per cycle into an internal word store. Any round key can then be read by
//   round number, in either forward (encrypt) or reversed (decrypt) order.
//   Because the whole schedule is kept, decryption can start from the last
//   round key without running the expansion again.
//
// Parameters:
//   KEY_BITS       cipher key length: 128, 192 or 256
//
// Ports:
//   clk_sys        system clock, all logic on its rising edge
//   rst_n          synchronous active-low reset
//   key_start      one-cycle pulse: load cipher_key and start expansion
//   cipher_key     cipher key, most significant word is w[0]
//   key_clear      (only with AES_KEY_ZEROIZE_EN) wipe store and return to idle
//   key_busy       expansion in progress
//   key_ready      store holds a complete schedule
//   rk_idx         requested round number 0..NR
//   rk_dec         0: return round rk_idx, 1: return round NR-rk_idx
//   round_key_out  registered round key, word 4r in [127:96]
//
// Build option:
//   AES_KEY_ZEROIZE_EN  adds the key_clear zeroize input
// ---------------------------------------------------------------------------
module aes_key_schedule_store #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk_sys,
   input  logic                rst_n,
   input  logic                key_start,
   input  logic [KEY_BITS-1:0] cipher_key,
`ifdef AES_KEY_ZEROIZE_EN
   input  logic                key_clear,
`endif
   output logic                key_busy,
   output logic                key_ready,
   input  logic [3:0]          rk_idx,
   input  logic                rk_dec,
   output logic [127:0]        round_key_out
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;

   // Reject unsupported key lengths at elaboration time.
   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_key_schedule_store: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   // Forward AES S-box, byte 0x00 in the top 8 bits.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte b sits at bits 8*(255-b)+7 downto 8*(255-b); 255-b is simply ~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]  state;
   logic [5:0]  word_cnt;
   logic [2:0]  phase;
   logic [7:0]  rcon;
   logic [31:0] store [NW];

   logic        clear_req;
   logic        start_ok;
   logic [5:0]  prev_idx;
   logic [31:0] temp;
   logic [31:0] prev_word;
   logic [31:0] mix_word;
   logic [31:0] next_word;
   logic [3:0]  eff_round;
   logic [5:0]  base;

`ifdef AES_KEY_ZEROIZE_EN
   assign clear_req = key_clear;
`else
   assign clear_req = 1'b0;
`endif

   // A start pulse is only honoured outside of an ongoing expansion.
   assign start_ok  = key_start && (state != ST_EXPAND);
   assign key_busy  = (state == ST_EXPAND);
   assign key_ready = (state == ST_READY);

   // Next schedule word. phase tracks i mod NK so no divider is needed for
   // the 192-bit case; temp is w[i-1] and prev_word is w[i-NK].
   always_comb begin
      prev_idx  = word_cnt - 6'(NK);
      temp      = store[word_cnt - 6'd1];
      prev_word = store[prev_idx];
      if (phase == 3'd0) begin
         mix_word = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
      end else if (NK == 8 && phase == 3'd4) begin
         mix_word = sub_word(temp);
      end else begin
         mix_word = temp;
      end
      next_word = prev_word ^ mix_word;
   end

   // Read address: decrypt order mirrors the round number around NR. An
   // out-of-range rk_idx may wrap here but is masked in the output register.
   always_comb begin
      eff_round = rk_dec ? (4'(NR) - rk_idx) : rk_idx;
      base      = {eff_round, 2'b00};
   end

   // Control FSM: IDLE -> EXPAND on a start, EXPAND -> READY after the last
   // word, READY -> EXPAND again on a re-key. Zeroize ranks just below reset.
   always_ff @(posedge clk_sys) begin
      if (!rst_n || clear_req) begin
         state    <= ST_IDLE;
         word_cnt <= 6'd0;
         phase    <= 3'd0;
         rcon     <= 8'h00;
      end else begin
         case (state)
            ST_IDLE, ST_READY: begin
               if (key_start) begin
                  state    <= ST_EXPAND;
                  word_cnt <= 6'(NK);
                  phase    <= 3'd0;
                  rcon     <= 8'h01;
               end
            end
            ST_EXPAND: begin
               if (phase == 3'd0) begin
                  rcon <= xtime(rcon);
               end
               phase    <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
               word_cnt <= word_cnt + 6'd1;
               if (word_cnt == 6'(NW - 1)) begin
                  state <= ST_READY;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Word store. It has no reset so contents survive a reset; only a
   // zeroize wipes it. Writes are suppressed while reset is asserted so
   // that reset wins over both start and zeroize.
   always_ff @(posedge clk_sys) begin
      if (rst_n) begin
         if (clear_req) begin
            for (int k = 0; k < NW; k++) begin
               store[k] <= 32'h0;
            end
         end else if (start_ok) begin
            for (int k = 0; k < NK; k++) begin
               store[k] <= cipher_key[KEY_BITS-1-32*k -: 32];
            end
         end else if (state == ST_EXPAND) begin
            store[word_cnt] <= next_word;
         end
      end
   end

   // Round key output register. A re-key issued while READY forces zero on
   // the same edge, since the store is about to be overwritten.
   always_ff @(posedge clk_sys) begin
      if (!rst_n || clear_req) begin
         round_key_out <= 128'h0;
      end else if (state == ST_READY && !key_start && rk_idx <= 4'(NR)) begin
         round_key_out <= {store[base], store[base + 6'd1],
                           store[base + 6'd2], store[base + 6'd3]};
      end else begin
         round_key_out <= 128'h0;
      end
   end

endmodule

// File: tb/tb_aes_key_schedule_store.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_store
//
// Purpose:
//   Self-checking bench for aes_key_schedule_store. One instance per key
//   length (128/192/256) shares clock, reset and read controls; sel routes
//   key_start to one instance and picks which outputs are observed.
//   Expected round keys come from a FIPS-197 style expansion written with
//   plain loops, using an S-box derived from GF(2^8) inversion plus the
//   affine map rather than a lookup table.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_store;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic         key_start_any;
   int           sel;
   logic [255:0] key_reg;
   logic [3:0]   rk_idx;
   logic         rk_dec;
`ifdef AES_KEY_ZEROIZE_EN
   logic         key_clear;
`endif

   logic         busy_a, busy_b, busy_c;
   logic         ready_a, ready_b, ready_c;
   logic [127:0] rko_a, rko_b, rko_c;
   logic         busy_sel, ready_sel;
   logic [127:0] rko_sel;

   int total = 0;
   int bad   = 0;

   logic [7:0]  sbox_tb [256];
   logic [31:0] mw [60];
   int          cur_nk;
   logic        model_valid;

   always #5 clk_sys = ~clk_sys;

   aes_key_schedule_store #(.KEY_BITS(128)) dut_a (
      .clk_sys       (clk_sys),
      .rst_n         (rst_n),
      .key_start     (key_start_any && sel == 0),
      .cipher_key    (key_reg[127:0]),
`ifdef AES_KEY_ZEROIZE_EN
      .key_clear     (key_clear),
`endif
      .key_busy      (busy_a),
      .key_ready     (ready_a),
      .rk_idx        (rk_idx),
      .rk_dec        (rk_dec),
      .round_key_out (rko_a)
   );

   aes_key_schedule_store #(.KEY_BITS(192)) dut_b (
      .clk_sys       (clk_sys),
      .rst_n         (rst_n),
      .key_start     (key_start_any && sel == 1),
      .cipher_key    (key_reg[191:0]),
`ifdef AES_KEY_ZEROIZE_EN
      .key_clear     (key_clear),
`endif
      .key_busy      (busy_b),
      .key_ready     (ready_b),
      .rk_idx        (rk_idx),
      .rk_dec        (rk_dec),
      .round_key_out (rko_b)
   );

   aes_key_schedule_store #(.KEY_BITS(256)) dut_c (
      .clk_sys       (clk_sys),
      .rst_n         (rst_n),
      .key_start     (key_start_any && sel == 2),
      .cipher_key    (key_reg),
`ifdef AES_KEY_ZEROIZE_EN
      .key_clear     (key_clear),
`endif
      .key_busy      (busy_c),
      .key_ready     (ready_c),
      .rk_idx        (rk_idx),
      .rk_dec        (rk_dec),
      .round_key_out (rko_c)
   );

   assign busy_sel  = (sel == 0) ? busy_a  : (sel == 1) ? busy_b  : busy_c;
   assign ready_sel = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
   assign rko_sel   = (sel == 0) ? rko_a   : (sel == 1) ? rko_b   : rko_c;

   // ---------------- reference model ----------------

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_tb(input logic [31:0] w);
      return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
   endfunction

   // Round constant for round n is x^(n-1) in GF(2^8).
   function automatic logic [7:0] rcon_of(input int n);
      logic [7:0] rc;
      rc = 8'h01;
      for (int j = 1; j < n; j++) rc = gmul(rc, 8'h02);
      return rc;
   endfunction

   task automatic model_expand(input logic [255:0] key, input int nk);
      int nw;
      logic [31:0] t;
      nw = 4 * (nk + 7);
      cur_nk = nk;
      for (int k = 0; k < nk; k++) mw[k] = key[32*(nk-1-k) +: 32];
      for (int i = nk; i < nw; i++) begin
         t = mw[i-1];
         if (i % nk == 0) t = sub_tb({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
         else if (nk > 6 && i % nk == 4) t = sub_tb(t);
         mw[i] = mw[i-nk] ^ t;
      end
      model_valid = 1'b1;
   endtask

   function automatic logic [127:0] expected_rk(input int idx, input int dec);
      int nr, e;
      nr = cur_nk + 6;
      if (!model_valid || idx > nr) return 128'h0;
      e = (dec != 0) ? nr - idx : idx;
      return {mw[4*e], mw[4*e+1], mw[4*e+2], mw[4*e+3]};
   endfunction

   // ---------------- bench tasks ----------------

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic readRound(input int idx, input int dec, input string tag);
      rk_idx = 4'(idx);
      rk_dec = (dec != 0);
      tick();
      checkOutput(tag, rko_sel, expected_rk(idx, dec));
   endtask

   task automatic sweepRounds(input string tag);
      for (int r = 0; r < cur_nk + 7; r++) begin
         readRound(r, 0, {tag, "_fwd"});
         readRound(r, 1, {tag, "_dec"});
      end
   endtask

   // Start an expansion on instance s and follow it to completion. glitch
   // re-pulses key_start (with a different key) on that busy cycle; abort
   // asserts reset on that busy cycle instead of letting it finish.
   task automatic applyStimulus(input int s, input logic [255:0] key,
                                input int glitch, input int abort);
      int cnt;
      int nk;
      nk  = 4 + 2 * s;
      sel = s;
      key_reg = key;
      key_start_any = 1'b1;
      tick();
      key_start_any = 1'b0;
      model_expand(key, nk);
      checkOutput("start_ready_low", 128'(ready_sel), 128'h0);
      checkOutput("start_rko_zero", rko_sel, 128'h0);
      cnt = 0;
      while (busy_sel === 1'b1 && cnt < 200) begin
         cnt++;
         if (cnt == abort) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            model_valid = 1'b0;
            checkOutput("abort_busy", 128'(busy_sel), 128'h0);
            checkOutput("abort_ready", 128'(ready_sel), 128'h0);
            checkOutput("abort_rko", rko_sel, 128'h0);
            return;
         end
         if (cnt == glitch) begin
            key_start_any = 1'b1;
            key_reg = ~key;
         end
         tick();
         key_start_any = 1'b0;
         key_reg = key;
      end
      checkOutput("busy_cycles", 128'(cnt), 128'(4 * (nk + 7) - nk));
      checkOutput("ready_after", 128'(ready_sel), 128'h1);
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- directed sequence ----------------

   initial begin
      logic [255:0] k;
      build_sbox();
      model_valid   = 1'b0;
      cur_nk        = 4;
      rst_n         = 1'b0;
      key_start_any = 1'b0;
      sel           = 0;
      key_reg       = '0;
      rk_idx        = 4'd0;
      rk_dec        = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
      key_clear     = 1'b0;
`endif
      tick();
      tick();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checkOutput("reset_busy", 128'(busy_sel), 128'h0);
         checkOutput("reset_ready", 128'(ready_sel), 128'h0);
         checkOutput("reset_rko", rko_sel, 128'h0);
      end
      rst_n = 1'b1;
      tick();

      // Known-answer vectors
      applyStimulus(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, -1, -1);
      rk_idx = 4'd10; rk_dec = 1'b0; tick();
      checkOutput("kat128_r10", rko_sel, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rk_idx = 4'd0; rk_dec = 1'b1; tick();
      checkOutput("kat128_dec0", rko_sel, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      sweepRounds("kat128");

      applyStimulus(1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, -1, -1);
      rk_idx = 4'd12; rk_dec = 1'b0; tick();
      checkOutput("kat192_r12", rko_sel, 128'he98ba06f448c773c8ecc720401002202);
      rk_idx = 4'd0; rk_dec = 1'b0; tick();
      checkOutput("kat192_r0", rko_sel, 128'h8e73b0f7da0e6452c810f32b809079e5);
      sweepRounds("kat192");

      applyStimulus(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, -1, -1);
      rk_idx = 4'd14; rk_dec = 1'b0; tick();
      checkOutput("kat256_r14", rko_sel, 128'hfe4890d1e6188d0b046df344706c631e);
      rk_idx = 4'd15; rk_dec = 1'b0; tick();
      checkOutput("kat256_r15", rko_sel, 128'h0);
      sweepRounds("kat256");

      // Random keys with random read requests, including out-of-range rounds
      for (int s = 0; s < 3; s++) begin
         repeat (2) begin
            applyStimulus(s, rand_key(), -1, -1);
            repeat (10) readRound(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), "rand_read");
         end
      end

      // key_start during expansion is ignored
      k = rand_key();
      applyStimulus(0, k, 20, -1);
      sweepRounds("ignore_start");

      // Re-key from READY with the all-zero key
      rk_idx = 4'd10; rk_dec = 1'b0;
      applyStimulus(0, 256'h0, -1, -1);
      rk_idx = 4'd10; rk_dec = 1'b0; tick();
      checkOutput("zero_key_r10", rko_sel, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Reset mid-expansion, reads stay zero until a fresh expansion
      rk_idx = 4'd5;
      applyStimulus(0, rand_key(), -1, 10);
      for (int r = 0; r < 4; r++) readRound(r * 3, 0, "after_abort");
      applyStimulus(0, rand_key(), -1, -1);
      sweepRounds("after_reexpand");

`ifdef AES_KEY_ZEROIZE_EN
      // Zeroize from READY, then re-expand the all-zero key
      sel = 0;
      rk_idx = 4'd3; rk_dec = 1'b0;
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      model_valid = 1'b0;
      checkOutput("clear_ready", 128'(ready_sel), 128'h0);
      checkOutput("clear_busy", 128'(busy_sel), 128'h0);
      checkOutput("clear_rko", rko_sel, 128'h0);
      readRound(3, 0, "clear_read");
      applyStimulus(0, 256'h0, -1, -1);
      sweepRounds("clear_reexpand");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
